spi_storage_responder: RTL and testbench
========================================

Name: spi_storage_responder

Overview:
- SPI target (mode 0, MSB first) implementing the responder side of the external-storage read protocol that our storage SPI master drives: opcode 0x03 + 24-bit address, then streamed read bytes.
- Also accepts page program (0x02), write enable/disable (0x06/0x04) and read status (0x05), so the programming path can be exercised against it.
- Backed by a byte-wide synchronous memory port with a fixed 1-cycle read latency.
- Used as the on-chip flash stand-in for the storage SPI master and as the storage model in system benches.

Parameters:
MEM_AW, 12, byte-address width of the backing memory; SPI addresses are truncated to MEM_AW bits.
SYNC_STAGES, 2, synchronizer depth for spi_cs_n, spi_sck and spi_mosi (minimum 2).

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
spi_cs_n  input  1  chip select, active low
spi_sck  input  1  SPI clock; frequency must be at most clk/8
spi_mosi  input  1  controller-to-target data
spi_miso  output  1  target-to-controller data; 0 when not driving
spi_miso_oe  output  1  high while this block drives spi_miso
mem_req  output  1  one-cycle memory access strobe
mem_we  output  1  write qualifier for mem_req
mem_addr  output  MEM_AW  byte address
mem_wdata  output  8  write byte
mem_rdata  input  8  read byte, valid the cycle after mem_req with mem_we=0
wel  output  1  write-enable latch
cmd_active  output  1  high from the synchronized CS fall to the synchronized CS rise

Behaviour:
- Reset values: all outputs 0; state IDLE; bit counter, shift registers and address register cleared.
- Reset is asynchronous at any time, including mid-transaction; the block recovers on the next CS fall.
- spi_cs_n, spi_sck and spi_mosi each pass through SYNC_STAGES flops before use.
- Edges are detected on the synchronized sck. MOSI is sampled on sck rise; MISO is updated on sck fall.
- bit_cnt is 3 bits. A byte completes on the 8th rise after CS fall or after the previous byte.
- State IDLE: wait for the synchronized CS fall, then go to CMD with bit_cnt=0.
- State CMD, after 8 bits:
  - 0x03 or 0x02 -> ADDR, with addr_byte_cnt=0.
  - 0x05 -> STATUS. Status byte = {6'b0, wel, 1'b0}; WIP always reads 0.
  - 0x06 -> sets wel, then IGNORE.
  - 0x04 -> clears wel, then IGNORE.
  - Any other opcode -> IGNORE.
- State ADDR:
  - Shifts in 3 bytes, MSB first; only the low MEM_AW bits are kept.
  - For a read, on the 24th bit: mem_req=1, mem_we=0, then load mem_rdata into the TX shift register the next cycle and go to READ_DATA.
  - For a program: go to PROG_DATA.
- State READ_DATA:
  - On each sck fall, shift out the next bit and drive spi_miso_oe=1.
  - On the first rise of each byte, increment the address (wrapping modulo 2^MEM_AW) and issue the prefetch for the next byte.
  - The prefetched byte is loaded when the current byte completes.
  - Streaming is unbounded until CS rises.
- State PROG_DATA:
  - Each completed byte triggers one cycle of mem_req=1, mem_we=1 at the current address, then addr[7:0] increments. The page wraps within 256 bytes; upper bits are unchanged.
  - If wel=0, bytes are consumed but no mem_req is issued.
- State STATUS: repeats the status byte for as long as sck toggles.
- State IGNORE: drives nothing and waits for the CS rise.
- CS rise (synchronized), in any state:
  - Return to IDLE, clear spi_miso_oe, and discard any partial byte; no write of a partial byte.
  - If a program command received at least one full data byte with wel=1, clear wel.
- spi_miso_oe is 0 in IDLE, CMD, ADDR, PROG_DATA and IGNORE. spi_miso=0 whenever spi_miso_oe=0.
- At most one mem_req per clk. A program write and a read prefetch cannot coincide, because the modes are exclusive.

Decomposition:
- Package spi_storage_pkg holds:
  - opcode constants OP_READ=8'h03, OP_PROG=8'h02, OP_RDSR=8'h05, OP_WREN=8'h06, OP_WRDI=8'h04;
  - the state enum typedef;
  - the PAGE_BYTES=256 constant.
- One sub-module, spi_edge_sync: synchronizer plus rise/fall pulse generation for sck, and level sync for cs_n/mosi.

Test Plan:
- Memory preloaded with 0x10=0xDE, 0x11=0xAD, 0x12=0xBE, 0x13=0xEF. Send 03 00 00 10, clock 32 bits -> MISO returns DE AD BE EF; exactly 4 prefetch mem_req plus the initial one.
- Read starting at 0xFFE with MEM_AW=12 over 4 bytes -> bytes from 0xFFE, 0xFFF, 0x000, 0x001.
- Send 06, then 02 00 01 FE with data 11 22 33, then CS rise -> writes 0x1FE=11, 0x1FF=22, 0x100=33 (page wrap); wel goes 1 then 0; a following 05 returns 0x00.
- Send 02 00 00 20 with data AA while wel=0 -> no mem_req with mem_we=1; 05 returns 0x00. After 06, 05 returns 0x02.
- CS rises after 5 bits of a program data byte -> no write issued; next command decodes normally.
- Assert rst mid-read-stream -> all outputs 0 asynchronously; after deassert, a new 03 read returns correct data.

Source files
------------

// File: rtl/spi_storage_pkg.sv
// Shared opcodes, FSM states and page geometry for the SPI storage responder.
package spi_storage_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PROG = 8'h02;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;

    localparam int PAGE_BYTES = 256;
    localparam int PAGE_AW    = $clog2(PAGE_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_READ_DATA,
        ST_PROG_DATA,
        ST_STATUS,
        ST_IGNORE
    } state_e;

    // WIP never reads busy: writes complete in a single clock.
    function automatic logic [7:0] status_byte(input logic wel);
        return {6'b0, wel, 1'b0};
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizes the SPI pins into clk and produces single-cycle sck/cs edge pulses.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cs_n,
    input  logic sck,
    input  logic mosi,
    output logic mosi_s,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_fall,
    output logic cs_rise
);

    // One extra stage on sck/cs gives the previous synchronized value for edge detection.
    logic [SYNC_STAGES:0]   sck_q, sck_d;
    logic [SYNC_STAGES:0]   cs_q, cs_d;
    logic [SYNC_STAGES-1:0] mosi_q, mosi_d;

    always_comb begin
        sck_d  = {sck_q[SYNC_STAGES-1:0], sck};
        cs_d   = {cs_q[SYNC_STAGES-1:0], cs_n};
        mosi_d = {mosi_q[SYNC_STAGES-2:0], mosi};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q  <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
        end else begin
            sck_q  <= sck_d;
            cs_q   <= cs_d;
            mosi_q <= mosi_d;
        end
    end

    assign mosi_s   = mosi_q[SYNC_STAGES-1];
    assign sck_rise =  sck_q[SYNC_STAGES-1] & ~sck_q[SYNC_STAGES];
    assign sck_fall = ~sck_q[SYNC_STAGES-1] &  sck_q[SYNC_STAGES];
    assign cs_fall  = ~cs_q[SYNC_STAGES-1]  &  cs_q[SYNC_STAGES];
    assign cs_rise  =  cs_q[SYNC_STAGES-1]  & ~cs_q[SYNC_STAGES];

endmodule

// File: rtl/spi_storage_responder.sv
// SPI mode-0 flash stand-in: read (03), page program (02), WREN/WRDI (06/04), RDSR (05)
// over a byte-wide memory port with one cycle of read latency.
module spi_storage_responder
    import spi_storage_pkg::*;
#(
    parameter int MEM_AW      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs_n,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              wel,
    output logic              cmd_active
);

    logic mosi_s, sck_rise, sck_fall, cs_fall, cs_rise;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .cs_n     (spi_cs_n),
        .sck      (spi_sck),
        .mosi     (spi_mosi),
        .mosi_s   (mosi_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise)
    );

    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]        addr_byte_cnt_q, addr_byte_cnt_d;
    logic [7:0]        rx_q, rx_d, tx_q, tx_d, pf_q, pf_d, mem_wdata_q, mem_wdata_d;
    logic [MEM_AW-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
    logic              is_read_q, is_read_d, wel_q, wel_d, miso_q, miso_d, miso_oe_q, miso_oe_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d, pf_kind_q, pf_kind_d;
    logic              ld_q, ld_d, ld_pf_q, ld_pf_d, prog_wrote_q, prog_wrote_d;
    logic              cmd_active_q, cmd_active_d;

    logic [7:0]        rx_shift;
    logic [MEM_AW-1:0] addr_shift, addr_inc, page_inc;
    logic              byte_done;

    assign rx_shift   = {rx_q[6:0], mosi_s};
    assign addr_shift = {addr_q[MEM_AW-2:0], mosi_s};
    assign addr_inc   = addr_q + MEM_AW'(1);
    assign page_inc   = {addr_q[MEM_AW-1:PAGE_AW], addr_q[PAGE_AW-1:0] + PAGE_AW'(1)};
    assign byte_done  = sck_rise && (bit_cnt_q == 3'd7);

    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        addr_byte_cnt_d = addr_byte_cnt_q;
        rx_d            = rx_q;
        tx_d            = tx_q;
        pf_d            = pf_q;
        addr_d          = addr_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        is_read_d       = is_read_q;
        wel_d           = wel_q;
        miso_d          = miso_q;
        miso_oe_d       = miso_oe_q;
        prog_wrote_d    = prog_wrote_q;
        cmd_active_d    = cmd_active_q;
        mem_req_d       = 1'b0;
        mem_we_d        = 1'b0;
        pf_kind_d       = 1'b0;
        ld_d            = mem_req_q & ~mem_we_q;
        ld_pf_d         = pf_kind_q;

        // Read data returns the cycle after the strobe: initial fetch goes straight to TX,
        // prefetches park in pf_q until the current byte finishes.
        if (ld_q) begin
            if (ld_pf_q) pf_d = mem_rdata;
            else         tx_d = mem_rdata;
        end

        if (cs_rise) begin
            state_d      = ST_IDLE;
            bit_cnt_d    = 3'd0;
            miso_d       = 1'b0;
            miso_oe_d    = 1'b0;
            cmd_active_d = 1'b0;
            prog_wrote_d = 1'b0;
            if (prog_wrote_q) wel_d = 1'b0;
        end else begin
            if (sck_rise && state_q != ST_IDLE) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                rx_d      = rx_shift;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d      = ST_CMD;
                        bit_cnt_d    = 3'd0;
                        cmd_active_d = 1'b1;
                    end
                end
                ST_CMD: begin
                    if (byte_done) begin
                        addr_byte_cnt_d = 2'd0;
                        case (rx_shift)
                            OP_READ: begin state_d = ST_ADDR; is_read_d = 1'b1; end
                            OP_PROG: begin state_d = ST_ADDR; is_read_d = 1'b0; end
                            OP_RDSR: begin state_d = ST_STATUS; tx_d = status_byte(wel_q); end
                            OP_WREN: begin state_d = ST_IGNORE; wel_d = 1'b1; end
                            OP_WRDI: begin state_d = ST_IGNORE; wel_d = 1'b0; end
                            default: state_d = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        addr_d = addr_shift;
                        if (bit_cnt_q == 3'd7) begin
                            if (addr_byte_cnt_q == 2'd2) begin
                                if (is_read_q) begin
                                    mem_req_d  = 1'b1;
                                    mem_addr_d = addr_shift;
                                    state_d    = ST_READ_DATA;
                                end else begin
                                    state_d    = ST_PROG_DATA;
                                end
                            end else begin
                                addr_byte_cnt_d = addr_byte_cnt_q + 2'd1;
                            end
                        end
                    end
                end
                ST_READ_DATA: begin
                    if (sck_fall) begin
                        miso_d    = tx_q[7];
                        tx_d      = {tx_q[6:0], 1'b0};
                        miso_oe_d = 1'b1;
                    end else if (sck_rise) begin
                        if (bit_cnt_q == 3'd0) begin
                            addr_d     = addr_inc;
                            mem_addr_d = addr_inc;
                            mem_req_d  = 1'b1;
                            pf_kind_d  = 1'b1;
                        end
                        if (bit_cnt_q == 3'd7) tx_d = pf_q;
                    end
                end
                ST_STATUS: begin
                    if (sck_fall) begin
                        miso_d    = tx_q[7];
                        tx_d      = {tx_q[6:0], 1'b0};
                        miso_oe_d = 1'b1;
                    end else if (byte_done) begin
                        tx_d = status_byte(wel_q);
                    end
                end
                ST_PROG_DATA: begin
                    if (byte_done) begin
                        if (wel_q) begin
                            mem_req_d    = 1'b1;
                            mem_we_d     = 1'b1;
                            mem_addr_d   = addr_q;
                            mem_wdata_d  = rx_shift;
                            prog_wrote_d = 1'b1;
                        end
                        addr_d = page_inc;
                    end
                end
                ST_IGNORE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            bit_cnt_q       <= '0;
            addr_byte_cnt_q <= '0;
            rx_q            <= '0;
            tx_q            <= '0;
            pf_q            <= '0;
            addr_q          <= '0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            is_read_q       <= 1'b0;
            wel_q           <= 1'b0;
            miso_q          <= 1'b0;
            miso_oe_q       <= 1'b0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            pf_kind_q       <= 1'b0;
            ld_q            <= 1'b0;
            ld_pf_q         <= 1'b0;
            prog_wrote_q    <= 1'b0;
            cmd_active_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            addr_byte_cnt_q <= addr_byte_cnt_d;
            rx_q            <= rx_d;
            tx_q            <= tx_d;
            pf_q            <= pf_d;
            addr_q          <= addr_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            is_read_q       <= is_read_d;
            wel_q           <= wel_d;
            miso_q          <= miso_d;
            miso_oe_q       <= miso_oe_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            pf_kind_q       <= pf_kind_d;
            ld_q            <= ld_d;
            ld_pf_q         <= ld_pf_d;
            prog_wrote_q    <= prog_wrote_d;
            cmd_active_q    <= cmd_active_d;
        end
    end

    assign spi_miso    = miso_q & miso_oe_q;
    assign spi_miso_oe = miso_oe_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign wel         = wel_q;
    assign cmd_active  = cmd_active_q;

endmodule

// File: tb/tb_spi_storage_responder.sv
// Directed bench for spi_storage_responder: table-driven reads and status decodes,
// plus hand sequences for programming, partial bytes and mid-stream reset.
module tb_spi_storage_responder;

    localparam int MEM_AW = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              spi_cs_n, spi_sck, spi_mosi;
    logic              spi_miso, spi_miso_oe;
    logic              mem_req, mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata = 8'h00;
    logic              wel, cmd_active;

    always #5 clk = ~clk;

    spi_storage_responder #(.MEM_AW(MEM_AW), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_cs_n    (spi_cs_n),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .wel         (wel),
        .cmd_active  (cmd_active)
    );

    // Backing memory model with one cycle of read latency; writes are logged.
    logic [7:0]  mem [0:4095];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [19:0] got_q[$];
    logic [19:0] exp_q[$];

    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                wr_cnt        <= wr_cnt + 1;
                got_q.push_back({mem_addr, mem_wdata});
            end else begin
                mem_rdata <= mem[mem_addr];
                rd_cnt    <= rd_cnt + 1;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
        r = '0;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            repeat (8) @(negedge clk);
            r[i] = spi_miso;
            spi_sck = 1'b1;
            repeat (8) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] b, output logic [7:0] r);
        spi_bits(b, 8, r);
    endtask

    task automatic cs_low();
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (8) @(negedge clk);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
        logic [7:0] r;
        xfer(op, r);
        xfer(a[23:16], r);
        xfer(a[15:8], r);
        xfer(a[7:0], r);
    endtask

    task automatic spi_read(input logic [23:0] a, output logic [31:0] d, output logic oe);
        logic [7:0] r;
        d = '0;
        cs_low();
        send_hdr(8'h03, a);
        for (int k = 0; k < 4; k++) begin
            xfer(8'h00, r);
            d = {d[23:0], r};
        end
        oe = spi_miso_oe;
        cs_high();
    endtask

    task automatic send_cmd(input logic [7:0] op);
        logic [7:0] r;
        cs_low();
        xfer(op, r);
        cs_high();
    endtask

    task automatic rdsr(output logic [7:0] s1, output logic [7:0] s2);
        logic [7:0] r;
        cs_low();
        xfer(8'h05, r);
        xfer(8'h00, s1);
        xfer(8'h00, s2);
        cs_high();
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [7:0] op;
        logic [7:0] exp_sr;
    } sr_vec_t;

    rd_vec_t rd_tbl[3];
    sr_vec_t sr_tbl[4];

    initial begin
        logic [31:0] d;
        logic        oe;
        logic [7:0]  s1, s2, r;
        int          rd0, wr0;

        rst      = 1'b1;
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h010] = 8'hDE; mem[12'h011] = 8'hAD; mem[12'h012] = 8'hBE; mem[12'h013] = 8'hEF;
        mem[12'h014] = 8'h77;
        mem[12'hFFE] = 8'h5A; mem[12'hFFF] = 8'hA5; mem[12'h000] = 8'h3C; mem[12'h001] = 8'hC3;

        rd_tbl[0] = '{24'h000010, 32'hDEADBEEF};
        rd_tbl[1] = '{24'h000FFE, 32'h5AA53CC3};
        rd_tbl[2] = '{24'h123011, 32'hADBEEF77};

        sr_tbl[0] = '{8'h06, 8'h02};
        sr_tbl[1] = '{8'h9F, 8'h02};
        sr_tbl[2] = '{8'h04, 8'h00};
        sr_tbl[3] = '{8'hAB, 8'h00};

        repeat (4) @(negedge clk);
        check("reset_ctrl", 32'({spi_miso, spi_miso_oe, mem_req, mem_we, wel, cmd_active}), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        check("reset_mem_wdata", 32'(mem_wdata), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        cs_low();
        check("cmd_active_high", 32'(cmd_active), 32'd1);
        cs_high();
        check("cmd_active_low", 32'(cmd_active), 32'd0);

        for (int i = 0; i < 3; i++) begin
            rd0 = rd_cnt;
            spi_read(rd_tbl[i].addr, d, oe);
            check($sformatf("read_data_%0d", i), d, rd_tbl[i].exp);
            check($sformatf("read_req_count_%0d", i), 32'(rd_cnt - rd0), 32'd5);
            check($sformatf("read_oe_on_%0d", i), 32'(oe), 32'd1);
            check($sformatf("read_oe_off_%0d", i), 32'(spi_miso_oe), 32'd0);
        end

        for (int i = 0; i < 4; i++) begin
            send_cmd(sr_tbl[i].op);
            check($sformatf("wel_after_op_%0d", i), 32'(wel), 32'(sr_tbl[i].exp_sr[1]));
            rdsr(s1, s2);
            check($sformatf("rdsr_first_%0d", i), 32'(s1), 32'(sr_tbl[i].exp_sr));
            check($sformatf("rdsr_repeat_%0d", i), 32'(s2), 32'(sr_tbl[i].exp_sr));
        end

        // Page program with wrap from 0x1FF back to 0x100.
        send_cmd(8'h06);
        check("prog_wel_set", 32'(wel), 32'd1);
        got_q.delete();
        wr0 = wr_cnt;
        cs_low();
        send_hdr(8'h02, 24'h0001FE);
        xfer(8'h11, r);
        xfer(8'h22, r);
        xfer(8'h33, r);
        check("prog_oe_quiet", 32'(spi_miso_oe), 32'd0);
        cs_high();
        exp_q.push_back({12'h1FE, 8'h11});
        exp_q.push_back({12'h1FF, 8'h22});
        exp_q.push_back({12'h100, 8'h33});
        check("prog_write_count", 32'(wr_cnt - wr0), 32'd3);
        while (exp_q.size() > 0) begin
            logic [19:0] e;
            e = exp_q.pop_front();
            check("prog_write", 32'(got_q.size() > 0 ? got_q.pop_front() : 20'hFFFFF), 32'(e));
        end
        check("prog_mem_100", 32'(mem[12'h100]), 32'h33);
        check("prog_wel_cleared", 32'(wel), 32'd0);
        rdsr(s1, s2);
        check("prog_rdsr", 32'(s1), 32'h00);

        // Program while write-disabled: bytes swallowed.
        wr0 = wr_cnt;
        cs_low();
        send_hdr(8'h02, 24'h000020);
        xfer(8'hAA, r);
        cs_high();
        check("nowel_write_count", 32'(wr_cnt - wr0), 32'd0);
        check("nowel_mem_020", 32'(mem[12'h020]), 32'h00);
        rdsr(s1, s2);
        check("nowel_rdsr", 32'(s1), 32'h00);
        send_cmd(8'h06);
        rdsr(s1, s2);
        check("wren_rdsr", 32'(s1), 32'h02);

        // Partial data byte: no write, wel kept, next command decodes.
        wr0 = wr_cnt;
        cs_low();
        send_hdr(8'h02, 24'h000030);
        spi_bits(8'h55, 5, r);
        cs_high();
        check("partial_write_count", 32'(wr_cnt - wr0), 32'd0);
        check("partial_wel_kept", 32'(wel), 32'd1);
        spi_read(24'h000010, d, oe);
        check("partial_next_read", d, 32'hDEADBEEF);

        // Asynchronous reset in the middle of a read stream.
        cs_low();
        send_hdr(8'h03, 24'h000010);
        xfer(8'h00, r);
        check("midrst_first_byte", 32'(r), 32'hDE);
        spi_bits(8'h00, 3, r);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_ctrl", 32'({spi_miso, spi_miso_oe, mem_req, mem_we, wel, cmd_active}), 32'd0);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        spi_read(24'h000010, d, oe);
        check("midrst_recover_read", d, 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
